// File: rtl/sram_responder_if.sv
// MEM-stage request bus and external SRAM pins for sram_responder.
// The slave modport is the responder's view; the master modport is the surrounding system's view.
interface sram_responder_if #(
    parameter int SRAM_AW = 18
) ();
    logic               MEM_R_EN;
    logic               MEM_W_EN;
    logic [31:0]        address;
    logic [31:0]        wdata;
    logic [31:0]        rdata;
    logic               ready;
    logic [SRAM_AW-1:0] SRAM_ADDR;
    logic [15:0]        SRAM_DQ_OUT;
    logic               SRAM_DQ_OE;
    logic [15:0]        SRAM_DQ_IN;
    logic               SRAM_WE_N;

    modport slave (
        input  MEM_R_EN, MEM_W_EN, address, wdata, SRAM_DQ_IN,
        output rdata, ready, SRAM_ADDR, SRAM_DQ_OUT, SRAM_DQ_OE, SRAM_WE_N
    );

    modport master (
        output MEM_R_EN, MEM_W_EN, address, wdata, SRAM_DQ_IN,
        input  rdata, ready, SRAM_ADDR, SRAM_DQ_OUT, SRAM_DQ_OE, SRAM_WE_N
    );
endinterface

// File: rtl/sram_responder.sv
// Serves 32-bit MEM-stage loads/stores as two 16-bit asynchronous SRAM accesses.
// ready stays low until the access completes, so upstream can freeze on ~ready.
module sram_responder #(
    parameter int WAIT_CYCLES = 1,
    parameter int SRAM_AW     = 18
) (
    input  logic           clk,
    input  logic           rst,
    sram_responder_if.slave bus
);
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t             state_reg;
    logic [3:0]         wcnt_reg;
    logic               is_write_reg;
    logic [SRAM_AW-2:0] word_addr_reg;
    logic [15:0]        wdata_hi_reg;
    logic [31:0]        rdata_reg;
    logic [SRAM_AW-1:0] sram_addr_reg;
    logic [15:0]        dq_out_reg;
    logic               dq_oe_reg;
    logic               we_n_reg;

    logic req;
    logic last;
    logic we_low_next;
    logic unused_addr_bits;

    assign req         = bus.MEM_R_EN | bus.MEM_W_EN;
    assign last        = (wcnt_reg == WAIT_LAST);
    // Write strobe for the next cycle of the same phase; the final cycle keeps WE high for data hold.
    assign we_low_next = is_write_reg && ((wcnt_reg + 4'd1) < WAIT_LAST);

    assign unused_addr_bits = ^{bus.address[31:SRAM_AW+1], bus.address[1:0]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= IDLE;
            wcnt_reg      <= 4'd0;
            is_write_reg  <= 1'b0;
            word_addr_reg <= '0;
            wdata_hi_reg  <= 16'h0;
            rdata_reg     <= 32'h0;
            sram_addr_reg <= '0;
            dq_out_reg    <= 16'h0;
            dq_oe_reg     <= 1'b0;
            we_n_reg      <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req) begin
                        state_reg     <= LOW;
                        wcnt_reg      <= 4'd0;
                        is_write_reg  <= bus.MEM_W_EN;
                        word_addr_reg <= bus.address[SRAM_AW:2];
                        wdata_hi_reg  <= bus.wdata[31:16];
                        sram_addr_reg <= {bus.address[SRAM_AW:2], 1'b0};
                        dq_out_reg    <= bus.MEM_W_EN ? bus.wdata[15:0] : 16'h0;
                        dq_oe_reg     <= bus.MEM_W_EN;
                        we_n_reg      <= ~bus.MEM_W_EN;
                    end
                end
                LOW, HIGH: begin
                    if (!last) begin
                        wcnt_reg <= wcnt_reg + 4'd1;
                        we_n_reg <= ~we_low_next;
                    end else if (state_reg == LOW) begin
                        state_reg     <= HIGH;
                        wcnt_reg      <= 4'd0;
                        sram_addr_reg <= {word_addr_reg, 1'b1};
                        dq_out_reg    <= is_write_reg ? wdata_hi_reg : 16'h0;
                        we_n_reg      <= ~is_write_reg;
                        if (!is_write_reg) begin
                            rdata_reg[15:0] <= bus.SRAM_DQ_IN;
                        end
                    end else begin
                        state_reg     <= DONE;
                        wcnt_reg      <= 4'd0;
                        sram_addr_reg <= '0;
                        dq_out_reg    <= 16'h0;
                        dq_oe_reg     <= 1'b0;
                        we_n_reg      <= 1'b1;
                        if (!is_write_reg) begin
                            rdata_reg[31:16] <= bus.SRAM_DQ_IN;
                        end
                    end
                end
                // A request still held here belongs to the access just finished.
                DONE: state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.ready       = (state_reg == IDLE) ? ~req : (state_reg == DONE);
    assign bus.rdata       = rdata_reg;
    assign bus.SRAM_ADDR   = sram_addr_reg;
    assign bus.SRAM_DQ_OUT = dq_out_reg;
    assign bus.SRAM_DQ_OE  = dq_oe_reg;
    assign bus.SRAM_WE_N   = we_n_reg;
endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: two instances (WAIT_CYCLES 1 and 3) on behavioural SRAMs,
// checked every cycle against a timeline model plus directed literal expectations.
module tb_sram_responder;
    localparam int AW  = 18;
    localparam int WC0 = 1;
    localparam int WC1 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        r_en[2];
    logic        w_en[2];
    logic [31:0] addr_in[2];
    logic [31:0] wdata_in[2];

    logic          ready_s[2];
    logic          oe_s[2];
    logic          we_s[2];
    logic [AW-1:0] sa_s[2];
    logic [15:0]   dqo_s[2];
    logic [31:0]   rdata_s[2];

    logic [15:0] sram[2][2048];
    logic [15:0] exp_mem[2][2048];

    sram_responder_if #(.SRAM_AW(AW)) bus0 ();
    sram_responder_if #(.SRAM_AW(AW)) bus1 ();

    sram_responder #(.WAIT_CYCLES(WC0), .SRAM_AW(AW)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    sram_responder #(.WAIT_CYCLES(WC1), .SRAM_AW(AW)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    assign bus0.MEM_R_EN   = r_en[0];
    assign bus0.MEM_W_EN   = w_en[0];
    assign bus0.address    = addr_in[0];
    assign bus0.wdata      = wdata_in[0];
    assign bus0.SRAM_DQ_IN = sram[0][bus0.SRAM_ADDR[10:0]];
    assign bus1.MEM_R_EN   = r_en[1];
    assign bus1.MEM_W_EN   = w_en[1];
    assign bus1.address    = addr_in[1];
    assign bus1.wdata      = wdata_in[1];
    assign bus1.SRAM_DQ_IN = sram[1][bus1.SRAM_ADDR[10:0]];

    assign ready_s[0] = bus0.ready;       assign ready_s[1] = bus1.ready;
    assign oe_s[0]    = bus0.SRAM_DQ_OE;  assign oe_s[1]    = bus1.SRAM_DQ_OE;
    assign we_s[0]    = bus0.SRAM_WE_N;   assign we_s[1]    = bus1.SRAM_WE_N;
    assign sa_s[0]    = bus0.SRAM_ADDR;   assign sa_s[1]    = bus1.SRAM_ADDR;
    assign dqo_s[0]   = bus0.SRAM_DQ_OUT; assign dqo_s[1]   = bus1.SRAM_DQ_OUT;
    assign rdata_s[0] = bus0.rdata;       assign rdata_s[1] = bus1.rdata;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit checking = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int wc(input int lane);
        return (lane == 0) ? WC0 : WC1;
    endfunction

    function automatic logic [15:0] init_hw(input int lane, input int i);
        return 16'(i * 40503 + lane * 7 + 3);
    endfunction

    // Async SRAM: a half-word is committed on the data-hold cycle that follows a WE low strobe.
    logic arm[2];
    int   we_fall[2];
    int   we_low[2];
    int   oe_cnt[2];
    logic we_hist[2];
    initial begin
        for (int l = 0; l < 2; l++) begin
            we_fall[l] = 0; we_low[l] = 0; oe_cnt[l] = 0; arm[l] = 1'b0; we_hist[l] = 1'b1;
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int l = 0; l < 2; l++) begin
            if (cyc == 0) begin
                for (int i = 0; i < 2048; i++) sram[l][i] <= init_hw(l, i);
            end else if (oe_s[l] === 1'b1 && we_s[l] === 1'b1 && arm[l]) begin
                sram[l][sa_s[l][10:0]] <= dqo_s[l];
            end
            arm[l]     <= (we_s[l] === 1'b0);
            we_hist[l] <= we_s[l];
            if (we_s[l] === 1'b0 && we_hist[l] === 1'b1) we_fall[l] <= we_fall[l] + 1;
            if (we_s[l] === 1'b0) we_low[l] <= we_low[l] + 1;
            if (oe_s[l] === 1'b1) oe_cnt[l] <= oe_cnt[l] + 1;
        end
    end

    // Reference model: each access is a timeline indexed by cycles since it was accepted.
    bit          m_busy[2];
    int          m_start[2];
    bit          m_wr[2];
    logic [9:0]  m_a[2];
    logic [31:0] m_wd[2];
    logic [31:0] m_rd[2];

    always @(negedge clk) begin
        if (cyc == 1) begin
            for (int l = 0; l < 2; l++) begin
                for (int i = 0; i < 2048; i++) exp_mem[l][i] = init_hw(l, i);
                m_busy[l] = 1'b0; m_rd[l] = 32'h0; m_start[l] = 0;
            end
        end
        if (checking) begin
            for (int l = 0; l < 2; l++) begin
                int w, n, k;
                bit rq, hi;
                logic e_ready, e_oe, e_we;
                logic [AW-1:0] e_addr;
                logic [15:0] e_dq;
                logic [10:0] idx;
                w  = wc(l);
                rq = r_en[l] | w_en[l];
                n  = cyc - m_start[l];
                e_ready = 1'b1; e_oe = 1'b0; e_we = 1'b1; e_addr = '0; e_dq = 16'h0;
                if (!m_busy[l]) begin
                    e_ready = !rq;
                end else if (n <= 2 * w + 2) begin
                    hi      = (n > w + 1);
                    k       = hi ? n - w - 2 : n - 1;
                    e_ready = 1'b0;
                    e_addr  = AW'({m_a[l], hi});
                    e_oe    = m_wr[l];
                    e_we    = !(m_wr[l] && k < w);
                    e_dq    = hi ? m_wd[l][31:16] : m_wd[l][15:0];
                end
                chk($sformatf("L%0d ready", l), 32'(ready_s[l]), 32'(e_ready));
                chk($sformatf("L%0d SRAM_ADDR", l), 32'(sa_s[l]), 32'(e_addr));
                chk($sformatf("L%0d SRAM_DQ_OE", l), 32'(oe_s[l]), 32'(e_oe));
                chk($sformatf("L%0d SRAM_WE_N", l), 32'(we_s[l]), 32'(e_we));
                chk($sformatf("L%0d rdata", l), rdata_s[l], m_rd[l]);
                if (e_oe) chk($sformatf("L%0d SRAM_DQ_OUT", l), 32'(dqo_s[l]), 32'(e_dq));

                if (rst !== 1'b1) begin
                    m_busy[l] = 1'b0;
                    m_rd[l]   = 32'h0;
                end else if (m_busy[l]) begin
                    if (n == w + 1 || n == 2 * w + 2) begin
                        hi  = (n == 2 * w + 2);
                        idx = {m_a[l], hi};
                        if (m_wr[l]) exp_mem[l][idx] = hi ? m_wd[l][31:16] : m_wd[l][15:0];
                        else if (hi) m_rd[l][31:16] = exp_mem[l][idx];
                        else         m_rd[l][15:0]  = exp_mem[l][idx];
                    end
                    if (n == 2 * w + 3) m_busy[l] = 1'b0;
                end else if (rq) begin
                    m_busy[l]  = 1'b1;
                    m_start[l] = cyc;
                    m_wr[l]    = w_en[l];
                    m_a[l]     = addr_in[l][11:2];
                    m_wd[l]    = wdata_in[l];
                end
            end
        end
    end

    task automatic posc();
        @(posedge clk);
        #1;
    endtask

    // Issue one access from posedge+1 and return at the negedge of its ready cycle.
    task automatic do_access(input int l, input bit r, input bit w, input logic [31:0] a,
                             input logic [31:0] d, input bit jitter);
        int lat;
        bit done;
        r_en[l] = r; w_en[l] = w; addr_in[l] = a; wdata_in[l] = d;
        lat = 0; done = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (ready_s[l] === 1'b1) begin
                done = 1'b1;
                lat  = i;
            end else begin
                posc();
                if (jitter && $urandom_range(0, 3) == 0) addr_in[l] = $urandom;
            end
        end
        chk($sformatf("L%0d access completes", l), 32'(done), 32'd1);
        chk($sformatf("L%0d latency", l), 32'(lat), 32'(2 * wc(l) + 3));
        $display("txn lane=%0d rd=%0d wr=%0d addr=%h wdata=%h lat=%0d rdata=%h",
                 l, r, w, a, d, lat, rdata_s[l]);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap, snap2, g, op;
        rst = 1'b0;
        for (int l = 0; l < 2; l++) begin
            r_en[l] = 1'b0; w_en[l] = 1'b0; addr_in[l] = 32'h0; wdata_in[l] = 32'h0;
        end
        posc();
        checking = 1'b1;
        @(negedge clk);
        chk("reset ready", 32'(ready_s[0]), 32'd1);
        chk("reset WE_N", 32'(we_s[0]), 32'd1);
        chk("reset DQ_OE", 32'(oe_s[0]), 32'd0);
        chk("reset ADDR", 32'(sa_s[1]), 32'd0);
        chk("reset DQ_OUT", 32'(dqo_s[1]), 32'd0);
        chk("reset rdata", rdata_s[1], 32'd0);
        posc();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle ready", 32'(ready_s[0]), 32'd1);

        // Store 0xDEADBEEF at 0x104 with per-cycle literal pins.
        posc();
        w_en[0] = 1'b1; addr_in[0] = 32'h0000_0104; wdata_in[0] = 32'hDEAD_BEEF;
        @(negedge clk); chk("st T ready", 32'(ready_s[0]), 32'd0);
        @(negedge clk); chk("st lo addr", 32'(sa_s[0]), 32'h082);
                        chk("st lo dq", 32'(dqo_s[0]), 32'hBEEF);
                        chk("st lo we", 32'(we_s[0]), 32'd0);
        @(negedge clk); chk("st lo hold we", 32'(we_s[0]), 32'd1);
        @(negedge clk); chk("st hi addr", 32'(sa_s[0]), 32'h083);
                        chk("st hi dq", 32'(dqo_s[0]), 32'hDEAD);
                        chk("st hi we", 32'(we_s[0]), 32'd0);
        @(negedge clk); chk("st T+4 ready", 32'(ready_s[0]), 32'd0);
        @(negedge clk); chk("st T+5 ready", 32'(ready_s[0]), 32'd1);
        posc();
        w_en[0] = 1'b0;
        @(negedge clk);
        chk("sram lo", 32'(sram[0][11'h082]), 32'hBEEF);
        chk("sram hi", 32'(sram[0][11'h083]), 32'hDEAD);

        posc();
        do_access(0, 1'b1, 1'b0, 32'h0000_0104, 32'h0, 1'b0);
        chk("load rdata", rdata_s[0], 32'hDEAD_BEEF);
        posc();
        do_access(0, 1'b1, 1'b1, 32'h0000_0200, 32'h1234_5678, 1'b0);
        chk("both-en rdata kept", rdata_s[0], 32'hDEAD_BEEF);
        chk("both-en sram lo", 32'(sram[0][11'h100]), 32'h5678);
        chk("both-en sram hi", 32'(sram[0][11'h101]), 32'h1234);

        // Held request through DONE performs one access; a request right after starts another.
        posc();
        r_en[0] = 1'b0; w_en[0] = 1'b0;
        posc();
        snap = we_fall[0];
        do_access(0, 1'b0, 1'b1, 32'h0000_0040, 32'hA1B2_C3D4, 1'b0);
        posc();
        w_en[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("held one access", 32'(we_fall[0] - snap), 32'd2);
        posc();
        snap = we_fall[0];
        do_access(0, 1'b0, 1'b1, 32'h0000_0044, 32'h0BAD_F00D, 1'b0);
        posc();
        do_access(0, 1'b1, 1'b1, 32'h0000_0048, 32'h7777_8888, 1'b0);
        posc();
        r_en[0] = 1'b0; w_en[0] = 1'b0;
        @(negedge clk);
        chk("back-to-back accesses", 32'(we_fall[0] - snap), 32'd4);

        // WAIT_CYCLES=3: load latency and strobe widths.
        posc();
        do_access(1, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
        posc();
        snap  = we_low[1];
        snap2 = oe_cnt[1];
        do_access(1, 1'b0, 1'b1, 32'h0000_0010, 32'h5555_AAAA, 1'b0);
        chk("W3 WE low cycles", 32'(we_low[1] - snap), 32'd6);
        chk("W3 OE cycles", 32'(oe_cnt[1] - snap2), 32'd8);
        posc();
        r_en[1] = 1'b0; w_en[1] = 1'b0;

        // Reset during the first HIGH cycle of a store.
        posc();
        w_en[0] = 1'b1; addr_in[0] = 32'h0000_0300; wdata_in[0] = 32'hCAFE_F00D;
        repeat (3) @(negedge clk);
        posc();
        rst = 1'b0; w_en[0] = 1'b0;
        @(negedge clk);
        chk("rst-in-hi addr", 32'(sa_s[0]), 32'h181);
        @(negedge clk);
        chk("after rst ready", 32'(ready_s[0]), 32'd1);
        chk("after rst WE_N", 32'(we_s[0]), 32'd1);
        chk("after rst OE", 32'(oe_s[0]), 32'd0);
        chk("after rst ADDR", 32'(sa_s[0]), 32'd0);
        chk("after rst rdata", rdata_s[0], 32'd0);
        posc();
        rst = 1'b1;
        @(negedge clk);
        chk("rst sram lo written", 32'(sram[0][11'h180]), 32'hF00D);
        chk("rst sram hi untouched", 32'(sram[0][11'h181]), 32'(init_hw(0, 32'h181)));

        // Randomized traffic on both lanes, checked by the model every cycle.
        for (int l = 0; l < 2; l++) begin
            posc();
            for (int t = 0; t < 40; t++) begin
                op = $urandom_range(0, 2);
                do_access(l, op != 1, op != 0,
                          {20'h0, 10'($urandom_range(0, 1023)), 2'($urandom_range(0, 3))},
                          $urandom, 1'b1);
                posc();
                g = $urandom_range(0, 2);
                if (g > 0) begin
                    r_en[l] = 1'b0; w_en[l] = 1'b0;
                    repeat (g) posc();
                end
            end
            r_en[l] = 1'b0; w_en[l] = 1'b0;
            repeat (2) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sram_responder.md
# sram_responder

Memory-side responder for the pipeline's MEM-stage load/store requests. It serves each 32-bit word access as two 16-bit accesses to an external asynchronous SRAM, and holds `ready` low until the access completes. Upstream logic uses `~ready` as a pipeline freeze. It sits between the MEM stage and the board SRAM, and replaces the single-cycle data memory.

## Interface
- `WAIT_CYCLES`, default 1: extra SRAM cycles per half-word phase. Legal range 1..15.
- `SRAM_AW`, default 18: SRAM half-word address width.
- `clk`, input, 1: system clock. All logic is on the rising edge.
- `rst`, input, 1: reset. **Synchronous, active-low.**
- `MEM_R_EN`, input, 1: load request. Held stable until `ready`.
- `MEM_W_EN`, input, 1: store request. Held stable until `ready`.
- `address`, input, 32: byte address. Bits [1:0] are ignored.
- `wdata`, input, 32: store data.
- `rdata`, output, 32: load result. Registered.
- `ready`, output, 1: access complete, or no access pending.
- `SRAM_ADDR`, output, SRAM_AW: half-word address.
- `SRAM_DQ_OUT`, output, 16: write data driven to the SRAM.
- `SRAM_DQ_OE`, output, 1: 1 = drive `SRAM_DQ_OUT` onto the bus.
- `SRAM_DQ_IN`, input, 16: read data from the bus.
- `SRAM_WE_N`, output, 1: SRAM write enable, active-low.

## Operation
- FSM states: IDLE, LOW, HIGH, DONE. A wait counter `wcnt` runs 0..WAIT_CYCLES inside each of LOW and HIGH.
- Request: `req = MEM_R_EN | MEM_W_EN`. If both enables are asserted, the access is a write.
- The write/read decision and the address are latched on entry to LOW. They do not change for the rest of the access.
- IDLE:
  - `ready = ~req`.
  - If `req`, go to LOW with `wcnt = 0`.
- LOW, low half:
  - `SRAM_ADDR = {address[SRAM_AW:2], 1'b0}`.
  - Stay for WAIT_CYCLES+1 cycles, then go to HIGH with `wcnt = 0`.
- HIGH, high half:
  - `SRAM_ADDR = {address[SRAM_AW:2], 1'b1}`.
  - Same duration as LOW, then go to DONE.
- DONE:
  - `ready = 1` for exactly one cycle.
  - Unconditionally go to IDLE. The request still being held in that cycle does not start a new access.
- Write phases:
  - `SRAM_DQ_OE = 1` for all cycles of the phase.
  - `SRAM_DQ_OUT` = `wdata[15:0]` in LOW, `wdata[31:16]` in HIGH.
  - `SRAM_WE_N = 0` while `wcnt < WAIT_CYCLES`. It is 1 on the final cycle of the phase, which gives data hold.
- Read phases:
  - `SRAM_DQ_OE = 0`, `SRAM_WE_N = 1`.
  - On the final cycle of LOW, `SRAM_DQ_IN` is registered into `rdata[15:0]`.
  - On the final cycle of HIGH, `SRAM_DQ_IN` is registered into `rdata[31:16]`.
- `rdata` is unchanged by writes. It holds the last load value until the next load overwrites it.
- In IDLE and DONE: `SRAM_WE_N = 1`, `SRAM_DQ_OE = 0`, `SRAM_ADDR = 0`.

## Timing
- Reset (`rst` = 0 at a clock edge):
  - State goes to IDLE and `wcnt` to 0.
  - `rdata = 0`.
  - `SRAM_WE_N = 1`, `SRAM_DQ_OE = 0`, `SRAM_ADDR = 0`, `SRAM_DQ_OUT = 0`.
  - `ready` = `~req` (combinational from IDLE).
- Reset mid-access: the access is abandoned at that edge. A partially written word is not reported, `rdata` is cleared, and no `ready` pulse is produced.
- Latency: a request first seen in IDLE in cycle T gives `ready = 1` in cycle T + 2·WAIT_CYCLES + 3. With WAIT_CYCLES = 1, that is T+5.
- `ready` is low in every cycle from T through T + 2·WAIT_CYCLES + 2.
- Back-to-back requests: the request held through DONE is consumed. A new request in the cycle after DONE (IDLE) starts the next access.
- Address or enable changes during LOW/HIGH are ignored. Only the values latched at IDLE→LOW are used.

## Test plan
- Store, then load (WAIT_CYCLES = 1):
  - Stimulus: store `wdata = 0xDEADBEEF` at `address = 0x0000_0104`.
  - Required: `SRAM_ADDR = 0x082` then `0x083`; `SRAM_DQ_OUT = 0xBEEF` then `0xDEAD`; `SRAM_WE_N` low for 1 cycle in each phase; `ready` at T+5.
  - Then load from the same address with an SRAM model: `rdata = 0xDEADBEEF` at T+5.
- No request: `ready = 1` continuously, `SRAM_WE_N = 1`, `SRAM_DQ_OE = 0`.
- Both enables set (`MEM_R_EN = MEM_W_EN = 1`): the access is a write. `rdata` keeps its previous value.
- WAIT_CYCLES = 3:
  - Load: `ready` at T+9.
  - Store: each phase is 4 cycles, with `SRAM_WE_N` low for 3 of them.
- Reset in the first HIGH cycle of a store: in the next cycle, outputs are at reset values and state is IDLE. The SRAM high half is never written.
- Request held across DONE: exactly one access is performed (exactly 2 SRAM half-word accesses). A new request in the following cycle starts a second access.
